// File: rtl/can_pkg.sv
// Shared CAN error/overload frame constants and state encoding.
// The receive-side detector imports the same lengths.
package can_pkg;

  typedef enum logic [1:0] {IDLE, FLAG, WAIT, DELIM} eof_tx_state_t;

  localparam int unsigned FLAG_LEN       = 6;
  localparam int unsigned DELIM_LEN      = 8;
  localparam int unsigned SUPERPOS_LIMIT = 14;
  localparam int unsigned SUPERPOS_STEP  = 8;

  localparam logic [4:0] CNT_FLAG_LAST  = 5'(FLAG_LEN - 1);
  localparam logic [4:0] CNT_DELIM_LAST = 5'(DELIM_LEN - 1);
  localparam logic [4:0] DOM_FIRST      = 5'(SUPERPOS_LIMIT);
  localparam logic [4:0] DOM_LAST       = 5'(SUPERPOS_LIMIT + SUPERPOS_STEP - 1);

  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

endpackage

// File: rtl/can_eof_tx_if.sv
// Controller/bus signals of the CAN error/overload frame transmitter.
interface can_eof_tx_if;
  logic RX;
  logic start_err;
  logic start_ovld;
  logic err_passive;
  logic TX;
  logic busy;
  logic frame_ovld;
  logic done;
  logic bit_err;
  logic superpos_err;

  modport master (
    output RX, start_err, start_ovld, err_passive,
    input  TX, busy, frame_ovld, done, bit_err, superpos_err
  );

  modport slave (
    input  RX, start_err, start_ovld, err_passive,
    output TX, busy, frame_ovld, done, bit_err, superpos_err
  );
endinterface

// File: rtl/can_eof_tx.sv
// CAN error/overload frame transmitter: flag, superposition wait, delimiter.
// Passive flag support is built only when CAN_EOF_TX_PASSIVE_EN is defined.
module can_eof_tx
  import can_pkg::*;
(
  input logic         SP,
  input logic         reset,
  can_eof_tx_if.slave bus
);

  eof_tx_state_t r_state, w_state_nxt;
  logic [4:0]    r_cnt, w_cnt_nxt;
  logic [4:0]    r_dom_cnt, w_dom_nxt;
  logic          r_passive, w_passive_nxt;
  logic          r_last_rx, w_last_rx_nxt;
  logic          r_tx, w_tx_nxt;
  logic          r_frame_ovld, w_ovld_nxt;
  logic          r_done, w_done_nxt;
  logic          r_bit_err, w_bit_err_nxt;
  logic          r_superpos_err, w_sp_err_nxt;
  logic          w_flag_start, w_flag_ovld;
  logic          w_passive_in;

`ifdef CAN_EOF_TX_PASSIVE_EN
  assign w_passive_in = bus.err_passive;
`else
  // Port kept for integration; every flag is active in this build.
  assign w_passive_in = 1'b0 & bus.err_passive;
`endif

  always_ff @(posedge SP or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_dom_cnt      <= '0;
      r_passive      <= 1'b0;
      r_last_rx      <= 1'b1;
      r_tx           <= 1'b1;
      r_frame_ovld   <= 1'b0;
      r_done         <= 1'b0;
      r_bit_err      <= 1'b0;
      r_superpos_err <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_dom_cnt      <= w_dom_nxt;
      r_passive      <= w_passive_nxt;
      r_last_rx      <= w_last_rx_nxt;
      r_tx           <= w_tx_nxt;
      r_frame_ovld   <= w_ovld_nxt;
      r_done         <= w_done_nxt;
      r_bit_err      <= w_bit_err_nxt;
      r_superpos_err <= w_sp_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_dom_nxt     = r_dom_cnt;
    w_passive_nxt = r_passive;
    w_last_rx_nxt = r_last_rx;
    w_ovld_nxt    = r_frame_ovld;
    w_done_nxt    = 1'b0;
    w_bit_err_nxt = 1'b0;
    w_sp_err_nxt  = 1'b0;
    w_flag_start  = 1'b0;
    w_flag_ovld   = 1'b0;
    w_tx_nxt      = 1'b1;

    case (r_state)
      IDLE: begin
        if (bus.start_err) begin
          w_flag_start = 1'b1;
        end else if (bus.start_ovld) begin
          w_flag_start = 1'b1;
          w_flag_ovld  = 1'b1;
        end
      end
      FLAG: begin
        if (!r_passive) begin
          if (r_cnt == CNT_FLAG_LAST) w_state_nxt = WAIT;
          else                        w_cnt_nxt   = sat_inc5(r_cnt);
        end else begin
          // Passive flag ends on six equal consecutive bus samples.
          w_last_rx_nxt = bus.RX;
          if (r_cnt == 5'd0 || bus.RX != r_last_rx) w_cnt_nxt   = 5'd1;
          else if (r_cnt == CNT_FLAG_LAST)          w_state_nxt = WAIT;
          else                                      w_cnt_nxt   = sat_inc5(r_cnt);
        end
      end
      WAIT: begin
        if (bus.RX) begin
          w_state_nxt = DELIM;
          w_cnt_nxt   = 5'd1;
        end else begin
          w_dom_nxt    = (r_dom_cnt == DOM_LAST) ? DOM_FIRST : r_dom_cnt + 5'd1;
          w_sp_err_nxt = (w_dom_nxt == DOM_FIRST);
        end
      end
      DELIM: begin
        if (bus.RX) begin
          if (r_cnt == CNT_DELIM_LAST) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = sat_inc5(r_cnt);
          end
        end else begin
          w_flag_start = 1'b1;
          if (r_cnt == CNT_DELIM_LAST) w_flag_ovld   = 1'b1;
          else                         w_bit_err_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_flag_start) begin
      w_state_nxt   = FLAG;
      w_cnt_nxt     = 5'd0;
      w_dom_nxt     = 5'd0;
      w_ovld_nxt    = w_flag_ovld;
      w_passive_nxt = w_passive_in;
    end

    w_tx_nxt = !((w_state_nxt == FLAG) && !w_passive_nxt);
  end

  assign bus.TX           = r_tx;
  assign bus.busy         = (r_state != IDLE);
  assign bus.frame_ovld   = r_frame_ovld;
  assign bus.done         = r_done;
  assign bus.bit_err      = r_bit_err;
  assign bus.superpos_err = r_superpos_err;

endmodule

// File: tb/tb_can_eof_tx.sv
// Randomized bench for can_eof_tx: frames are planned as segments
// (flag, extra dominant bits, optional delimiter disturbance) and expected traces computed per edge.
module tb_can_eof_tx;

  localparam int MAXE = 256;

  logic SP = 1'b0;
  logic reset;
  can_eof_tx_if bus();

  can_eof_tx u_dut (
    .SP    (SP),
    .reset (reset),
    .bus   (bus)
  );

  always #5 SP = ~SP;

  int n_checks = 0;
  int n_errors = 0;

  bit rx_q[MAXE], st_e[MAXE], st_o[MAXE];
  bit e_tx[MAXE], e_busy[MAXE], e_ovld[MAXE], e_done[MAXE], e_berr[MAXE], e_sp[MAXE];
  int seg_d[3], seg_p[3];
  int n_seg;
  int trial_len;
  bit cur_ovld = 1'b0;

  task automatic check_val(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < MAXE; i++) begin
      rx_q[i] = 1'b1; st_e[i] = 1'b0; st_o[i] = 1'b0;
      e_tx[i] = 1'b1; e_busy[i] = 1'b0; e_ovld[i] = cur_ovld;
      e_done[i] = 1'b0; e_berr[i] = 1'b0; e_sp[i] = 1'b0;
    end
  endtask

  // ftype: 0 = error request, 1 = overload request, 2 = both (error wins)
  task automatic build_trial(input int ftype);
    int e, ed, j;
    bit ovl;
    clear_exp();
    st_e[0] = (ftype != 1);
    st_o[0] = (ftype != 0);
    ovl = (ftype == 1);
    e = 0;
    ed = 0;
    for (int s = 0; s < n_seg; s++) begin
      for (int i = e; i < e + 6; i++) e_tx[i] = 1'b0;
      for (int i = e + 1; i <= e + 6; i++) rx_q[i] = 1'b0;
      for (int i = e; i < MAXE; i++) e_ovld[i] = ovl;
      for (int k = 1; k <= seg_d[s]; k++) begin
        rx_q[e + 6 + k] = 1'b0;
        if (k >= 14 && (k - 14) % 8 == 0) e_sp[e + 6 + k] = 1'b1;
      end
      if (seg_p[s] != 0) begin
        ed = e + 6 + seg_d[s] + seg_p[s];
        rx_q[ed] = 1'b0;
        if (seg_p[s] < 8) e_berr[ed] = 1'b1;
        ovl = (seg_p[s] == 8);
        e = ed;
      end else begin
        ed = e + 14 + seg_d[s];
        e_done[ed] = 1'b1;
      end
    end
    for (int i = 0; i < ed; i++) e_busy[i] = 1'b1;
    trial_len = ed + 4;
    cur_ovld = ovl;
    j = int'($urandom_range(1, ed));
    if ($urandom_range(0, 1) == 1) st_e[j] = 1'b1;
    else                           st_o[j] = 1'b1;
  endtask

  task automatic run_trial(input string name);
    bus.RX = rx_q[0]; bus.start_err = st_e[0]; bus.start_ovld = st_o[0];
    for (int j = 0; j < trial_len; j++) begin
      @(posedge SP);
      #1;
      check_val($sformatf("%s tx@%0d", name, j), bus.TX, e_tx[j]);
      check_val($sformatf("%s busy@%0d", name, j), bus.busy, e_busy[j]);
      check_val($sformatf("%s ovld@%0d", name, j), bus.frame_ovld, e_ovld[j]);
      check_val($sformatf("%s done@%0d", name, j), bus.done, e_done[j]);
      check_val($sformatf("%s bit_err@%0d", name, j), bus.bit_err, e_berr[j]);
      check_val($sformatf("%s superpos@%0d", name, j), bus.superpos_err, e_sp[j]);
      if (j + 1 < trial_len) begin
        bus.RX = rx_q[j + 1]; bus.start_err = st_e[j + 1]; bus.start_ovld = st_o[j + 1];
      end else begin
        bus.RX = 1'b1; bus.start_err = 1'b0; bus.start_ovld = 1'b0;
      end
    end
  endtask

  task automatic pick_passive();
`ifdef CAN_EOF_TX_PASSIVE_EN
    bus.err_passive = 1'b0;
`else
    bus.err_passive = 1'($urandom_range(0, 1));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ftype;
    reset = 1'b1;
    bus.RX = 1'b1; bus.start_err = 1'b0; bus.start_ovld = 1'b0; bus.err_passive = 1'b0;
    #12;
    check_val("reset tx", bus.TX, 1'b1);
    check_val("reset busy", bus.busy, 1'b0);
    check_val("reset ovld", bus.frame_ovld, 1'b0);
    check_val("reset done", bus.done, 1'b0);
    check_val("reset bit_err", bus.bit_err, 1'b0);
    check_val("reset superpos", bus.superpos_err, 1'b0);
    @(posedge SP);
    #1 reset = 1'b0;

    for (int t = 0; t < 45; t++) begin
      pick_passive();
      case (t)
        0: begin ftype = 0; n_seg = 1; seg_d[0] = 0;  seg_p[0] = 0; end
        1: begin ftype = 0; n_seg = 1; seg_d[0] = 6;  seg_p[0] = 0; end
        2: begin ftype = 1; n_seg = 1; seg_d[0] = 23; seg_p[0] = 0; end
        3: begin ftype = 0; n_seg = 2; seg_d[0] = 0;  seg_p[0] = 4; seg_d[1] = 0; seg_p[1] = 0; end
        4: begin ftype = 2; n_seg = 2; seg_d[0] = 2;  seg_p[0] = 8; seg_d[1] = 0; seg_p[1] = 0; end
        default: begin
          ftype = int'($urandom_range(0, 2));
          n_seg = int'($urandom_range(1, 3));
          for (int s = 0; s < 3; s++) begin
            seg_d[s] = int'($urandom_range(0, 25));
            seg_p[s] = (s < n_seg - 1) ? int'($urandom_range(2, 8)) : 0;
          end
        end
      endcase
      build_trial(ftype);
      run_trial($sformatf("trial%0d", t));
    end

    bus.err_passive = 1'b0;
    bus.start_err = 1'b1; bus.RX = 1'b1;
    @(posedge SP);
    #1;
    bus.start_err = 1'b0; bus.RX = 1'b0;
    check_val("midrst flag tx", bus.TX, 1'b0);
    @(posedge SP);
    @(posedge SP);
    #3 reset = 1'b1;
    #1;
    check_val("midrst tx", bus.TX, 1'b1);
    check_val("midrst busy", bus.busy, 1'b0);
    check_val("midrst done", bus.done, 1'b0);
    check_val("midrst ovld", bus.frame_ovld, 1'b0);
    @(posedge SP);
    #1;
    reset = 1'b0; bus.RX = 1'b1;
    cur_ovld = 1'b0;
    n_seg = 1; seg_d[0] = int'($urandom_range(0, 20)); seg_p[0] = 0;
    build_trial(1);
    run_trial("after_reset");

`ifdef CAN_EOF_TX_PASSIVE_EN
    clear_exp();
    st_e[0] = 1'b1;
    rx_q[1] = 1'b1;
    for (int i = 2; i <= 7; i++) rx_q[i] = 1'b0;
    for (int i = 0; i < MAXE; i++) e_ovld[i] = 1'b0;
    for (int i = 0; i < 15; i++) e_busy[i] = 1'b1;
    e_done[15] = 1'b1;
    trial_len = 19;
    bus.err_passive = 1'b1;
    run_trial("passive");
    bus.err_passive = 1'b0;
    cur_ovld = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
